clk_src_failover_ctrl: RTL
==========================

# clk_src_failover_ctrl

Sequencer for the 320 MHz fast-command clock mux. It qualifies the external clock from periodic rate measurements and drives the BUFGCTRL select between internal and external clocks. It blanks the fast-command stream around every switch, and fails over to the internal clock immediately when the external clock stops. It sits between the clock-stop/rate monitor and the clock/FC mux, in the mux's output clock domain, with register-bank fields for control and status.

## Interface
- RATE_MIN, 24'd319000: lowest acceptable rate measurement, inclusive.
- RATE_MAX, 24'd321000: highest acceptable rate measurement, inclusive.
- GOOD_COUNT, 4: consecutive in-range measurements required to qualify the external clock (≥1).
- BLANK_CYCLES, 64: cycles of FC blanking before and after a switch (≥1).

- clk  in  1  controller clock (internal 320 MHz).
- aresetn  in  1  reset; asynchronous, active-low.
- rate_valid  in  1  one-cycle strobe; rate_value is valid.
- rate_value  in  24  external clock rate measurement.
- ext_stopped  in  1  level; external clock stopped (already synchronized).
- auto_en  in  1  register field; allows automatic use of the external clock.
- force_int  in  1  register field; forces the internal clock.
- clk_int_sel  out  1  to BUFGCTRL S0 (S1 = inverse); 1 = internal clock.
- fc_blank  out  1  forces FC output to idle while high.
- ext_in_use  out  1  high only in state EXT.
- state  out  3  current state encoding, for status.
- switch_count  out  16  number of clk_int_sel toggles, saturating.
- fail_count  out  16  number of unplanned fallbacks, saturating.

## Operation
- States:
  - INT=000
  - PRE_EXT=001
  - POST_EXT=010
  - EXT=011
  - PRE_INT=100
  - POST_INT=101
  - 110/111 are illegal and return to POST_INT with clk_int_sel=1.
- good_cnt tracks external clock qualification.
  - Width is $clog2(GOOD_COUNT+1); it saturates at GOOD_COUNT.
  - In INT it increments on rate_valid when RATE_MIN ≤ rate_value ≤ RATE_MAX and ext_stopped=0.
  - It clears on an out-of-range rate_valid, on ext_stopped=1, and on every entry to INT.
- INT: clk_int_sel=1, fc_blank=0.
  - Go to PRE_EXT when good_cnt==GOOD_COUNT, auto_en=1, force_int=0 and ext_stopped=0.
  - Qualification continues while force_int=1, but no transition is taken.
- PRE_EXT: fc_blank=1 for BLANK_CYCLES cycles. On the last cycle, set clk_int_sel←0 and go to POST_EXT.
- POST_EXT: fc_blank=1 for BLANK_CYCLES cycles, then go to EXT.
- EXT: fc_blank=0, ext_in_use=1.
  - Failure exit: ext_stopped=1, or rate_valid with an out-of-range value. Set clk_int_sel←1 on the transition cycle, increment fail_count, and go to POST_INT (PRE_INT is skipped).
  - Planned exit: force_int=1 or auto_en=0. Go to PRE_INT.
  - When both apply in the same cycle, failure wins.
- PRE_INT: fc_blank=1 for BLANK_CYCLES cycles, then set clk_int_sel←1 and go to POST_INT.
  - ext_stopped=1 during PRE_INT aborts at once: clk_int_sel←1, fail_count+1, go to POST_INT.
- POST_INT: fc_blank=1 for BLANK_CYCLES cycles, then go to INT.
- ext_stopped=1 in PRE_EXT or POST_EXT aborts: clk_int_sel←1 next cycle, fail_count+1, go to POST_INT.
- Blank counter:
  - Width is $clog2(BLANK_CYCLES+1).
  - Loads 0 on each state entry and counts up to BLANK_CYCLES-1.
  - An abort restarts it in POST_INT.
- switch_count increments on every cycle where the registered clk_int_sel changes. Both counters saturate at 16'hFFFF.

## Timing
- All outputs are registered.
- Reset values: state=INT, clk_int_sel=1, fc_blank=0, ext_in_use=0, switch_count=0, fail_count=0, good_cnt=0.
- Reset mid-sequence returns to INT with clk_int_sel=1 asynchronously, without blanking.
- Qualifying rate_valid at cycle t: state=PRE_EXT and fc_blank=1 visible at t+1.
- clk_int_sel falls at the cycle after the last PRE_EXT cycle, coincident with entry to POST_EXT. fc_blank stays high for 2×BLANK_CYCLES contiguous cycles.
- ext_stopped rising at cycle t in EXT, PRE_EXT, POST_EXT or PRE_INT: clk_int_sel=1, state=POST_INT and fail_count incremented, all at t+1.
- rate_valid and ext_stopped in the same cycle: ext_stopped wins, and the measurement is ignored.
- Inputs are sampled every cycle. rate_valid pulses longer than one cycle count as multiple measurements.

## Test plan
- Reset, auto_en=1, four in-range measurements (320000) → PRE_EXT after the 4th. clk_int_sel=0 after 64 cycles, EXT after 128 cycles. fc_blank high for exactly 128 cycles. switch_count=1.
- In INT: three in-range measurements, one at 318999, four in-range → transition only after the final four. An in-range 321000 (inclusive boundary) is accepted.
- In EXT, assert ext_stopped → next cycle clk_int_sel=1, state=POST_INT, fail_count=1. INT reached 64 cycles later. switch_count=2.
- In EXT, set force_int=1 → PRE_INT with fc_blank=1. clk_int_sel=1 after 64 cycles, INT after 128. fail_count unchanged. Re-qualification is blocked until force_int=0.
- Assert ext_stopped in mid-PRE_EXT and separately in mid-PRE_INT → abort to POST_INT within one cycle, fail_count+1 each. Pulse aresetn low in mid-POST_EXT → immediate INT, clk_int_sel=1, counters 0.
- Preload switch_count to 16'hFFFE via repeated cycles (or force) → saturates at 16'hFFFF after two further switches.

Source files
------------

// File: rtl/clk_src_failover_ctrl.sv
// clk_src_failover_ctrl
// Sequences the 320 MHz fast-command clock mux between the internal and the
// external clock. The external clock is qualified from consecutive in-range
// rate measurements. The FC stream is blanked before and after every planned
// switch. The controller falls back to the internal clock at once when the
// external clock stops or reports a bad rate while it is in use.
//
// Ports
//   clk          in   controller clock (internal 320 MHz)
//   aresetn      in   asynchronous active-low reset
//   rate_valid   in   strobe, rate_value holds a measurement
//   rate_value   in   [23:0] external clock rate measurement
//   ext_stopped  in   level, external clock stopped (already synchronized)
//   auto_en      in   allows automatic use of the external clock
//   force_int    in   forces the internal clock
//   clk_int_sel  out  BUFGCTRL S0, 1 = internal clock
//   fc_blank     out  forces the FC output to idle while high
//   ext_in_use   out  high only in EXT
//   state        out  [2:0] current state encoding
//   switch_count out  [15:0] clk_int_sel toggles, saturating
//   fail_count   out  [15:0] unplanned fallbacks, saturating
module clk_src_failover_ctrl #(
  parameter logic [23:0] RATE_MIN     = 24'd319000,
  parameter logic [23:0] RATE_MAX     = 24'd321000,
  parameter int          GOOD_COUNT   = 4,
  parameter int          BLANK_CYCLES = 64
) (
  input  logic        clk,
  input  logic        aresetn,
  input  logic        rate_valid,
  input  logic [23:0] rate_value,
  input  logic        ext_stopped,
  input  logic        auto_en,
  input  logic        force_int,
  output logic        clk_int_sel,
  output logic        fc_blank,
  output logic        ext_in_use,
  output logic [2:0]  state,
  output logic [15:0] switch_count,
  output logic [15:0] fail_count
);

  localparam int GOOD_W  = $clog2(GOOD_COUNT + 1);
  localparam int BLANK_W = $clog2(BLANK_CYCLES + 1);
  localparam logic [GOOD_W-1:0]  GOOD_MAX   = GOOD_W'(GOOD_COUNT);
  localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'(BLANK_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_INT      = 3'b000,
    ST_PRE_EXT  = 3'b001,
    ST_POST_EXT = 3'b010,
    ST_EXT      = 3'b011,
    ST_PRE_INT  = 3'b100,
    ST_POST_INT = 3'b101
  } state_t;

  // Saturating 16-bit increment shared by both event counters.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      sat_inc16 = v;
    end else begin
      sat_inc16 = v + 16'd1;
    end
  endfunction

  state_t               state_r, state_s;
  logic                 clk_int_sel_r, clk_int_sel_s;
  logic                 fc_blank_r, fc_blank_s;
  logic                 ext_in_use_r, ext_in_use_s;
  logic [15:0]          switch_count_r, switch_count_s;
  logic [15:0]          fail_count_r, fail_count_s;
  logic [GOOD_W-1:0]    good_cnt_r, good_upd_s, good_cnt_s;
  logic [BLANK_W-1:0]   blank_cnt_r, blank_cnt_s;
  logic                 in_range_s, rate_ok_s, rate_bad_s, blank_done_s;

  // Measurement classification; a stopped clock overrides any measurement.
  assign in_range_s   = (rate_value >= RATE_MIN) && (rate_value <= RATE_MAX);
  assign rate_ok_s    = rate_valid && in_range_s && !ext_stopped;
  assign rate_bad_s   = rate_valid && !in_range_s;
  assign blank_done_s = (blank_cnt_r == BLANK_LAST);

  // Next-state, next-output and counter update logic.
  always_comb begin
    state_s        = state_r;
    clk_int_sel_s  = clk_int_sel_r;
    fail_count_s   = fail_count_r;
    good_upd_s     = good_cnt_r;
    good_cnt_s     = good_cnt_r;
    blank_cnt_s    = blank_cnt_r;
    switch_count_s = switch_count_r;
    fc_blank_s     = 1'b0;
    ext_in_use_s   = 1'b0;

    // Qualification only accumulates in INT but is lost anywhere on a bad sample.
    if (ext_stopped || rate_bad_s) begin
      good_upd_s = {GOOD_W{1'b0}};
    end else if (rate_ok_s && (state_r == ST_INT) && (good_cnt_r != GOOD_MAX)) begin
      good_upd_s = good_cnt_r + GOOD_W'(1);
    end else begin
      good_upd_s = good_cnt_r;
    end

    case (state_r)
      ST_INT: begin
        // Uses the updated count so the qualifying strobe moves state next cycle.
        if ((good_upd_s == GOOD_MAX) && auto_en && !force_int && !ext_stopped) begin
          state_s = ST_PRE_EXT;
        end else begin
          state_s = ST_INT;
        end
      end
      ST_PRE_EXT: begin
        if (ext_stopped) begin
          state_s       = ST_POST_INT;
          clk_int_sel_s = 1'b1;
          fail_count_s  = sat_inc16(fail_count_r);
        end else if (blank_done_s) begin
          state_s       = ST_POST_EXT;
          clk_int_sel_s = 1'b0;
        end else begin
          state_s = ST_PRE_EXT;
        end
      end
      ST_POST_EXT: begin
        if (ext_stopped) begin
          state_s       = ST_POST_INT;
          clk_int_sel_s = 1'b1;
          fail_count_s  = sat_inc16(fail_count_r);
        end else if (blank_done_s) begin
          state_s = ST_EXT;
        end else begin
          state_s = ST_POST_EXT;
        end
      end
      ST_EXT: begin
        // Failure is checked first so it wins over a planned exit.
        if (ext_stopped || rate_bad_s) begin
          state_s       = ST_POST_INT;
          clk_int_sel_s = 1'b1;
          fail_count_s  = sat_inc16(fail_count_r);
        end else if (force_int || !auto_en) begin
          state_s = ST_PRE_INT;
        end else begin
          state_s = ST_EXT;
        end
      end
      ST_PRE_INT: begin
        if (ext_stopped) begin
          state_s       = ST_POST_INT;
          clk_int_sel_s = 1'b1;
          fail_count_s  = sat_inc16(fail_count_r);
        end else if (blank_done_s) begin
          state_s       = ST_POST_INT;
          clk_int_sel_s = 1'b1;
        end else begin
          state_s = ST_PRE_INT;
        end
      end
      ST_POST_INT: begin
        if (blank_done_s) begin
          state_s = ST_INT;
        end else begin
          state_s = ST_POST_INT;
        end
      end
      default: begin
        // Illegal encodings recover through a full blanking period on the internal clock.
        state_s       = ST_POST_INT;
        clk_int_sel_s = 1'b1;
      end
    endcase

    if ((state_s == ST_INT) && (state_r != ST_INT)) begin
      good_cnt_s = {GOOD_W{1'b0}};
    end else begin
      good_cnt_s = good_upd_s;
    end

    if (state_s != state_r) begin
      blank_cnt_s = {BLANK_W{1'b0}};
    end else if (!blank_done_s) begin
      blank_cnt_s = blank_cnt_r + BLANK_W'(1);
    end else begin
      blank_cnt_s = blank_cnt_r;
    end

    if (clk_int_sel_s != clk_int_sel_r) begin
      switch_count_s = sat_inc16(switch_count_r);
    end else begin
      switch_count_s = switch_count_r;
    end

    if ((state_s == ST_INT) || (state_s == ST_EXT)) begin
      fc_blank_s = 1'b0;
    end else begin
      fc_blank_s = 1'b1;
    end

    if (state_s == ST_EXT) begin
      ext_in_use_s = 1'b1;
    end else begin
      ext_in_use_s = 1'b0;
    end
  end

  // State and registered-output update with asynchronous reset to INT.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_r        <= ST_INT;
      clk_int_sel_r  <= 1'b1;
      fc_blank_r     <= 1'b0;
      ext_in_use_r   <= 1'b0;
      switch_count_r <= 16'd0;
      fail_count_r   <= 16'd0;
      good_cnt_r     <= {GOOD_W{1'b0}};
      blank_cnt_r    <= {BLANK_W{1'b0}};
    end else begin
      state_r        <= state_s;
      clk_int_sel_r  <= clk_int_sel_s;
      fc_blank_r     <= fc_blank_s;
      ext_in_use_r   <= ext_in_use_s;
      switch_count_r <= switch_count_s;
      fail_count_r   <= fail_count_s;
      good_cnt_r     <= good_cnt_s;
      blank_cnt_r    <= blank_cnt_s;
    end
  end

  assign clk_int_sel  = clk_int_sel_r;
  assign fc_blank     = fc_blank_r;
  assign ext_in_use   = ext_in_use_r;
  assign state        = state_r;
  assign switch_count = switch_count_r;
  assign fail_count   = fail_count_r;

endmodule
